// File: rtl/display_pkg.sv
// Shared types and helpers for the seven-segment display scanner.
package display_pkg;

  typedef enum logic {
    S_GUARD = 1'b0,
    S_DRIVE = 1'b1
  } state_e;

  localparam logic [6:0] SEG_OFF    = 7'b0;
  localparam int         MAX_DIGITS = 32;

  function automatic logic [MAX_DIGITS-1:0] onehot(input int unsigned idx);
    onehot = {{(MAX_DIGITS-1){1'b0}}, 1'b1} << idx;
  endfunction

endpackage

// File: rtl/display_scanner_decoder.sv
// Hex nibble to seven-segment pattern (bit 0 = segment a, active-high).
module BCD_Decoder (
  input  logic [3:0] digit_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = 7'b0000000;
    case (digit_i)
      4'h0: seg_o = 7'b0111111;
      4'h1: seg_o = 7'b0000110;
      4'h2: seg_o = 7'b1011011;
      4'h3: seg_o = 7'b1001111;
      4'h4: seg_o = 7'b1100110;
      4'h5: seg_o = 7'b1101101;
      4'h6: seg_o = 7'b1111101;
      4'h7: seg_o = 7'b0000111;
      4'h8: seg_o = 7'b1111111;
      4'h9: seg_o = 7'b1101111;
      4'hA: seg_o = 7'b1110111;
      4'hB: seg_o = 7'b1111100;
      4'hC: seg_o = 7'b0111001;
      4'hD: seg_o = 7'b1011110;
      4'hE: seg_o = 7'b1111001;
      4'hF: seg_o = 7'b1110001;
      default: seg_o = 7'b0000000;
    endcase
  end

endmodule

// File: rtl/display_scanner.sv
// Time-multiplexed seven-segment driver: one digit at a time, guard gap between
// digits, new values committed only at the frame boundary.
module display_scanner
  import display_pkg::*;
#(
  parameter int DIGITS   = 4,
  parameter int PRESCALE = 50000,
  parameter int GUARD    = 500
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic                Load,
  input  logic [4*DIGITS-1:0] Value,
  input  logic                Blank,
  output logic [DIGITS-1:0]   Anode,
  output logic [6:0]          SevenSegment,
  output logic                Pending
);

  localparam int MAXC = (PRESCALE > GUARD) ? PRESCALE : GUARD;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam int IW   = $clog2(DIGITS);

  localparam logic [CW-1:0] GUARD_LAST = CW'(GUARD - 1);
  localparam logic [CW-1:0] DRIVE_LAST = CW'(PRESCALE - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);

  state_e              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [4*DIGITS-1:0] disp_q, disp_d;
  logic [4*DIGITS-1:0] shadow_q, shadow_d;
  logic                pending_q, pending_d;
  logic [DIGITS-1:0]   anode_q, anode_d;
  logic [6:0]          seg_q, seg_d;

  logic                guard_done;
  logic                drive_done;
  logic                boundary;
  logic [3:0]          nib [DIGITS];
  logic [DIGITS-1:0]   lz_mask;
  logic [6:0]          dec_seg;

  assign guard_done = (state_q == S_GUARD) && (cnt_q == GUARD_LAST);
  assign drive_done = (state_q == S_DRIVE) && (cnt_q == DRIVE_LAST);
  assign boundary   = guard_done && (idx_q == IDX_LAST);
  assign idx_d      = !guard_done ? idx_q : (boundary ? '0 : idx_q + 1'b1);

  // Mask and decoder look at the value being committed on this edge, so a load
  // in the boundary cycle is already visible on digit 0.
  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
    assign nib[gi] = disp_d[4*gi +: 4];
    if (gi == 0) begin : g_lsd
      assign lz_mask[gi] = 1'b0;
    end else begin : g_upper
      assign lz_mask[gi] = Blank && (disp_d[4*DIGITS-1:4*gi] == '0);
    end
  end

  BCD_Decoder u_decoder (
    .digit_i (nib[idx_d]),
    .seg_o   (dec_seg)
  );

  // Double buffer: a load in the boundary cycle bypasses the shadow.
  always_comb begin
    disp_d    = disp_q;
    shadow_d  = shadow_q;
    pending_d = pending_q;
    if (boundary) begin
      pending_d = 1'b0;
      if (Load) begin
        disp_d = Value;
      end else if (pending_q) begin
        disp_d = shadow_q;
      end
    end else if (Load) begin
      shadow_d  = Value;
      pending_d = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    anode_d = anode_q;
    seg_d   = seg_q;
    if (guard_done) begin
      state_d = S_DRIVE;
      cnt_d   = '0;
      anode_d = DIGITS'(onehot(32'(idx_d)));
      seg_d   = lz_mask[idx_d] ? SEG_OFF : dec_seg;
    end else if (drive_done) begin
      state_d = S_GUARD;
      cnt_d   = '0;
      anode_d = '0;
      seg_d   = SEG_OFF;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q   <= S_GUARD;
      cnt_q     <= '0;
      idx_q     <= IDX_LAST;
      disp_q    <= '0;
      shadow_q  <= '0;
      pending_q <= 1'b0;
      anode_q   <= '0;
      seg_q     <= SEG_OFF;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      disp_q    <= disp_d;
      shadow_q  <= shadow_d;
      pending_q <= pending_d;
      anode_q   <= anode_d;
      seg_q     <= seg_d;
    end
  end

  assign Anode        = anode_q;
  assign SevenSegment = seg_q;
  assign Pending      = pending_q;

endmodule

// File: tb/tb_display_scanner.sv
// Randomized and directed bench for display_scanner against a time-based model.
module tb_display_scanner;

  localparam int DIGITS   = 4;
  localparam int PRESCALE = 3;
  localparam int GUARD    = 1;
  localparam int SLOT     = PRESCALE + GUARD;
  localparam int FRAME    = DIGITS * SLOT;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        Load = 1'b0;
  logic [15:0] Value = '0;
  logic        Blank = 1'b0;
  logic [3:0]  Anode;
  logic [6:0]  SevenSegment;
  logic        Pending;

  display_scanner #(
    .DIGITS   (DIGITS),
    .PRESCALE (PRESCALE),
    .GUARD    (GUARD)
  ) dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .Load         (Load),
    .Value        (Value),
    .Blank        (Blank),
    .Anode        (Anode),
    .SevenSegment (SevenSegment),
    .Pending      (Pending)
  );

  always #5 Clk = ~Clk;

  logic [6:0] hex_seg [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  int          n_checks = 0;
  int          n_pass   = 0;
  int          t        = 0;   // cycles since reset released
  logic [15:0] m_disp, m_shadow;
  logic        m_pend;
  logic [3:0]  e_anode;
  logic [6:0]  e_seg;

  task automatic model_reset();
    t = 0; m_disp = '0; m_shadow = '0; m_pend = 1'b0;
    e_anode = '0; e_seg = '0;
  endtask

  task automatic do_reset();
    Load = 1'b0; Reset = 1'b1;
    repeat (2) @(posedge Clk);
    #1;
    Reset = 1'b0;
    model_reset();
  endtask

  // One clock of stimulus; the model derives the display purely from elapsed time.
  task automatic cycle(input bit ld, input logic [15:0] val, input bit blk);
    int ph, dig;
    logic [15:0] sh;
    Load = ld; Value = val; Blank = blk;
    if (ld) $display("t=%0d load value=%h blank=%0d", t, val, blk);
    @(posedge Clk);
    if (t % FRAME == 0) begin
      if (ld) m_disp = val;
      else if (m_pend) m_disp = m_shadow;
      m_pend = 1'b0;
    end else if (ld) begin
      m_shadow = val;
      m_pend   = 1'b1;
    end
    t++;
    ph  = t % SLOT;
    dig = (t / SLOT) % DIGITS;
    if (ph < GUARD) begin
      e_anode = '0;
      e_seg   = '0;
    end else begin
      e_anode = 4'(1 << dig);
      if (ph == GUARD) begin
        sh    = m_disp >> (4 * dig);
        e_seg = (dig > 0 && blk && sh == 16'h0) ? 7'h00 : hex_seg[sh[3:0]];
      end
    end
    #1;
    Load = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if (Anode !== 4'b0000) $display("FAIL reset_anode: got %b expected 0000", Anode); else n_pass++;
    n_checks++;
    if (SevenSegment !== 7'b0) $display("FAIL reset_seg: got %b expected 0000000", SevenSegment); else n_pass++;
    n_checks++;
    if (Pending !== 1'b0) $display("FAIL reset_pending: got %b expected 0", Pending); else n_pass++;
    for (int k = 0; k < 3; k++) begin
      cycle(1'b0, 16'h0, 1'b0);
      n_checks++;
      if (Anode !== 4'b0001) $display("FAIL reset_digit0_anode: t=%0d got %b expected 0001", t, Anode); else n_pass++;
      n_checks++;
      if (SevenSegment !== 7'b0111111) $display("FAIL reset_digit0_seg: t=%0d got %b expected 0111111", t, SevenSegment); else n_pass++;
    end
    cycle(1'b0, 16'h0, 1'b0);
    n_checks++;
    if (Anode !== 4'b0000) $display("FAIL reset_guard2_anode: got %b expected 0000", Anode); else n_pass++;
  endtask

  task automatic test_load_mid_frame();
    do_reset();
    repeat (5) cycle(1'b0, 16'h0, 1'b0);
    cycle(1'b1, 16'h1234, 1'b0);
    n_checks++;
    if (Pending !== 1'b1) $display("FAIL midload_pending: got %b expected 1", Pending); else n_pass++;
    while (t < 2 * FRAME) begin
      cycle(1'b0, 16'h0, 1'b0);
      n_checks++;
      if (Anode !== e_anode || SevenSegment !== e_seg || Pending !== m_pend)
        $display("FAIL midload_scan: t=%0d got %b/%b/%b expected %b/%b/%b",
                 t, Anode, SevenSegment, Pending, e_anode, e_seg, m_pend);
      else n_pass++;
      if (t == FRAME + GUARD) begin
        n_checks++;
        if (SevenSegment !== 7'b1100110 || Pending !== 1'b0)
          $display("FAIL midload_commit: got seg=%b pend=%b expected 1100110/0", SevenSegment, Pending);
        else n_pass++;
      end
    end
  endtask

  task automatic test_blanking();
    do_reset();
    cycle(1'b1, 16'h0070, 1'b1);
    while (t < 2 * FRAME) begin
      cycle(1'b0, 16'h0, 1'b1);
      n_checks++;
      if (Anode !== e_anode || SevenSegment !== e_seg)
        $display("FAIL blank_0070: t=%0d got %b/%b expected %b/%b", t, Anode, SevenSegment, e_anode, e_seg);
      else n_pass++;
      if (t % FRAME == 3 * SLOT + GUARD) begin
        n_checks++;
        if (Anode !== 4'b1000 || SevenSegment !== 7'b0)
          $display("FAIL blank_digit3: got %b/%b expected 1000/0000000", Anode, SevenSegment);
        else n_pass++;
      end
    end
    cycle(1'b1, 16'h0000, 1'b1);
    while (t < 4 * FRAME) begin
      cycle(1'b0, 16'h0, 1'b1);
      n_checks++;
      if (Anode !== e_anode || SevenSegment !== e_seg)
        $display("FAIL blank_0000: t=%0d got %b/%b expected %b/%b", t, Anode, SevenSegment, e_anode, e_seg);
      else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    repeat (2) cycle(1'b0, 16'h0, 1'b1);
    cycle(1'b1, 16'hAAAA, 1'b1);
    cycle(1'b0, 16'h0, 1'b1);
    cycle(1'b1, 16'h00F0, 1'b1);
    while (t < 3 * FRAME) begin
      cycle(1'b0, 16'h0, 1'b1);
      n_checks++;
      if (Anode !== e_anode || SevenSegment !== e_seg || SevenSegment === 7'b1110111)
        $display("FAIL b2b_scan: t=%0d got %b/%b expected %b/%b", t, Anode, SevenSegment, e_anode, e_seg);
      else n_pass++;
      if (t == FRAME + SLOT + GUARD) begin
        n_checks++;
        if (SevenSegment !== 7'b1110001)
          $display("FAIL b2b_digit1_F: got %b expected 1110001", SevenSegment);
        else n_pass++;
      end
    end
  endtask

  task automatic test_load_boundary();
    do_reset();
    repeat (3) cycle(1'b0, 16'h0, 1'b0);
    cycle(1'b1, 16'h1111, 1'b0);
    while (t % FRAME != 0) cycle(1'b0, 16'h0, 1'b0);
    cycle(1'b1, 16'h9999, 1'b0);
    n_checks++;
    if (SevenSegment !== 7'b1101111 || Pending !== 1'b0)
      $display("FAIL boundary_load: got seg=%b pend=%b expected 1101111/0", SevenSegment, Pending);
    else n_pass++;
    repeat (FRAME) begin
      cycle(1'b0, 16'h0, 1'b0);
      n_checks++;
      if (Anode !== e_anode || SevenSegment !== e_seg || Pending !== m_pend)
        $display("FAIL boundary_scan: t=%0d got %b/%b/%b expected %b/%b/%b",
                 t, Anode, SevenSegment, Pending, e_anode, e_seg, m_pend);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid_drive();
    do_reset();
    repeat (2) cycle(1'b0, 16'h0, 1'b0);
    cycle(1'b1, 16'h5555, 1'b0);
    while (t != 2 * SLOT + GUARD) cycle(1'b0, 16'h0, 1'b0);
    Reset = 1'b1;
    @(posedge Clk);
    #1;
    Reset = 1'b0;
    model_reset();
    n_checks++;
    if (Anode !== 4'b0 || SevenSegment !== 7'b0 || Pending !== 1'b0)
      $display("FAIL midreset_state: got %b/%b/%b expected 0000/0000000/0", Anode, SevenSegment, Pending);
    else n_pass++;
    repeat (FRAME + 2) begin
      cycle(1'b0, 16'h0, 1'b0);
      n_checks++;
      if (Anode !== e_anode || SevenSegment !== e_seg || Pending !== m_pend)
        $display("FAIL midreset_scan: t=%0d got %b/%b/%b expected %b/%b/%b",
                 t, Anode, SevenSegment, Pending, e_anode, e_seg, m_pend);
      else n_pass++;
    end
  endtask

  task automatic test_random();
    bit          ld, blk;
    logic [15:0] val;
    do_reset();
    repeat (400) begin
      ld  = ($urandom_range(0, 9) == 0);
      blk = $urandom_range(0, 1) == 1;
      val = 16'($urandom);
      if ($urandom_range(0, 2) == 0) val = val & 16'h00FF;
      cycle(ld, val, blk);
      n_checks++;
      if (Anode !== e_anode || SevenSegment !== e_seg || Pending !== m_pend)
        $display("FAIL random_scan: t=%0d got %b/%b/%b expected %b/%b/%b",
                 t, Anode, SevenSegment, Pending, e_anode, e_seg, m_pend);
      else n_pass++;
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1);
  end

  initial begin
    model_reset();
    test_reset();
    test_load_mid_frame();
    test_blanking();
    test_back_to_back();
    test_load_boundary();
    test_reset_mid_drive();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
